mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single combinational-read memory.
// The memory-side funct3 is legality-checked here; a response arrives one cycle after each transfer.
module mem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid_0,
    output logic                     req_ready_0,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_0,
    input  logic                     req_we_0,
    input  logic [DATA_WIDTH-1:0]    req_wdata_0,
    input  logic [2:0]               req_memctrl_0,
    output logic                     rsp_valid_0,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_0,
    output logic                     rsp_err_0,

    input  logic                     req_valid_1,
    output logic                     req_ready_1,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_1,
    input  logic                     req_we_1,
    input  logic [DATA_WIDTH-1:0]    req_wdata_1,
    input  logic [2:0]               req_memctrl_1,
    output logic                     rsp_valid_1,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_1,
    output logic                     rsp_err_1,

    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_writedata,
    output logic [2:0]               mem_memcontrol,
    input  logic [DATA_WIDTH-1:0]    mem_readdata
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    port_t last_grant;

    logic gnt_0;
    logic gnt_1;
    logic legal_0;
    logic legal_1;

    // Stores allow byte/half/word; loads additionally allow the unsigned byte/half forms.
    function automatic logic is_legal(input logic we, input logic [2:0] ctrl);
        if (we) begin
            return ctrl inside {3'b000, 3'b001, 3'b010};
        end
        return ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Gating with rst_n keeps ready low for the whole reset, not just after it.
    always_comb begin
        gnt_0 = rst_n && req_valid_0 && (!req_valid_1 || last_grant == PORT1);
        gnt_1 = rst_n && req_valid_1 && !gnt_0;
    end

    always_comb begin
        legal_0     = is_legal(req_we_0, req_memctrl_0);
        legal_1     = is_legal(req_we_1, req_memctrl_1);
        req_ready_0 = gnt_0;
        req_ready_1 = gnt_1;
    end

    always_comb begin
        mem_a          = '0;
        mem_we         = 1'b0;
        mem_writedata  = '0;
        mem_memcontrol = 3'b010;
        if (gnt_0) begin
            mem_a          = req_addr_0;
            mem_we         = req_we_0 && legal_0;
            mem_writedata  = req_wdata_0;
            mem_memcontrol = req_memctrl_0;
        end else if (gnt_1) begin
            mem_a          = req_addr_1;
            mem_we         = req_we_1 && legal_1;
            mem_writedata  = req_wdata_1;
            mem_memcontrol = req_memctrl_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= PORT1;
            rsp_valid_0 <= 1'b0;
            rsp_err_0   <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_valid_1 <= 1'b0;
            rsp_err_1   <= 1'b0;
            rsp_rdata_1 <= '0;
        end else begin
            if (gnt_0) begin
                last_grant <= PORT0;
            end else if (gnt_1) begin
                last_grant <= PORT1;
            end

            rsp_valid_0 <= gnt_0;
            rsp_err_0   <= gnt_0 && !legal_0;
            rsp_valid_1 <= gnt_1;
            rsp_err_1   <= gnt_1 && !legal_1;

            // Read data is held across stores and idle cycles; only loads or errors replace it.
            if (gnt_0) begin
                if (!legal_0) begin
                    rsp_rdata_0 <= '0;
                end else if (!req_we_0) begin
                    rsp_rdata_0 <= mem_readdata;
                end
            end
            if (gnt_1) begin
                if (!legal_1) begin
                    rsp_rdata_1 <= '0;
                end else if (!req_we_1) begin
                    rsp_rdata_1 <= mem_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model that
// performs funct3 byte/half extraction on reads and lane merging on writes.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_addr_0, req_addr_1;
    logic        req_we_0, req_we_1;
    logic [31:0] req_wdata_0, req_wdata_1;
    logic [2:0]  req_memctrl_0, req_memctrl_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_rdata_0, rsp_rdata_1;
    logic        rsp_err_0, rsp_err_1;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_writedata;
    logic [2:0]  mem_memcontrol;
    logic [31:0] mem_readdata;

    logic [31:0] mem [0:15];
    logic        mem_load;

    int checks;
    int failures;

    mem_arbiter #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_0(req_valid_0),
        .req_ready_0(req_ready_0),
        .req_addr_0(req_addr_0),
        .req_we_0(req_we_0),
        .req_wdata_0(req_wdata_0),
        .req_memctrl_0(req_memctrl_0),
        .rsp_valid_0(rsp_valid_0),
        .rsp_rdata_0(rsp_rdata_0),
        .rsp_err_0(rsp_err_0),
        .req_valid_1(req_valid_1),
        .req_ready_1(req_ready_1),
        .req_addr_1(req_addr_1),
        .req_we_1(req_we_1),
        .req_wdata_1(req_wdata_1),
        .req_memctrl_1(req_memctrl_1),
        .rsp_valid_1(rsp_valid_1),
        .rsp_rdata_1(rsp_rdata_1),
        .rsp_err_1(rsp_err_1),
        .mem_a(mem_a),
        .mem_we(mem_we),
        .mem_writedata(mem_writedata),
        .mem_memcontrol(mem_memcontrol),
        .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] c);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (c)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] wr_model(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] off, input logic [2:0] c);
        logic [31:0] m;
        logic [31:0] v;
        case (c)
            3'b000:  m = 32'h0000_00FF;
            3'b001:  m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        m = m << {off, 3'b000};
        v = d << {off, 3'b000};
        return (old & ~m) | (v & m);
    endfunction

    always_comb mem_readdata = rd_model(mem[mem_a[5:2]], mem_a[1:0], mem_memcontrol);

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h1122_3344;
            mem[1] <= 32'h5566_7788;
        end else if (mem_we) begin
            mem[mem_a[5:2]] <= wr_model(mem[mem_a[5:2]], mem_writedata, mem_a[1:0], mem_memcontrol);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic we,
                          input logic [31:0] d, input logic [2:0] c);
        req_valid_0 = v; req_addr_0 = a; req_we_0 = we; req_wdata_0 = d; req_memctrl_0 = c;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic we,
                          input logic [31:0] d, input logic [2:0] c);
        req_valid_1 = v; req_addr_1 = a; req_we_1 = we; req_wdata_1 = d; req_memctrl_1 = c;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        mem_load = 1'b1;
        drive0(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        drive1(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        tick();
        tick();
        mem_load = 1'b0;

        // Reset state, with a request pending that must not be accepted
        drive0(1'b1, 32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 3'b010);
        #1;
        chk1("rst_ready0", req_ready_0, 1'b0);
        chk1("rst_ready1", req_ready_1, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_memctrl", {29'h0, mem_memcontrol}, 32'h2);
        chk1("rst_rsp_valid0", rsp_valid_0, 1'b0);
        chk1("rst_rsp_err0", rsp_err_0, 1'b0);
        chk("rst_rdata0", rsp_rdata_0, 32'h0);
        chk("rst_rdata1", rsp_rdata_1, 32'h0);
        drive0(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);

        // Both valid right after reset release: port0 first, then port1
        @(negedge clk);
        rst_n = 1'b1;
        drive0(1'b1, 32'h0001_0000, 1'b0, 32'h0, 3'b010);
        drive1(1'b1, 32'h0001_0004, 1'b0, 32'h0, 3'b010);
        #1;
        chk1("c1_ready0", req_ready_0, 1'b1);
        chk1("c1_ready1", req_ready_1, 1'b0);
        chk("c1_mem_a", mem_a, 32'h0001_0000);
        tick();
        chk1("c1_rsp_valid0", rsp_valid_0, 1'b1);
        chk("c1_rdata0", rsp_rdata_0, 32'h1122_3344);
        chk1("c1_rsp_valid1", rsp_valid_1, 1'b0);
        chk1("c2_ready0", req_ready_0, 1'b0);
        chk1("c2_ready1", req_ready_1, 1'b1);
        chk("c2_mem_a", mem_a, 32'h0001_0004);
        tick();
        chk1("c2_rsp_valid1", rsp_valid_1, 1'b1);
        chk1("c2_rsp_valid0", rsp_valid_0, 1'b0);
        chk("c2_rdata1", rsp_rdata_1, 32'h5566_7788);

        // Six cycles of continuous contention alternate 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            chk1("rr_ready0", req_ready_0, (i % 2) == 0);
            chk1("rr_ready1", req_ready_1, (i % 2) == 1);
            tick();
            chk1("rr_rsp_valid0", rsp_valid_0, (i % 2) == 0);
            chk1("rr_rsp_valid1", rsp_valid_1, (i % 2) == 1);
        end

        // Port1 alone (last grant was port1): store then load
        drive0(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        drive1(1'b1, 32'h0001_0008, 1'b1, 32'hDEAD_BEEF, 3'b010);
        #1;
        chk1("st1_ready1", req_ready_1, 1'b1);
        chk1("st1_mem_we", mem_we, 1'b1);
        chk("st1_wdata", mem_writedata, 32'hDEAD_BEEF);
        tick();
        chk1("st1_rsp_valid1", rsp_valid_1, 1'b1);
        chk1("st1_rsp_err1", rsp_err_1, 1'b0);
        chk("st1_rdata1_hold", rsp_rdata_1, 32'h5566_7788);
        drive1(1'b1, 32'h0001_0008, 1'b0, 32'h0, 3'b010);
        #1;
        chk1("ld1_mem_we", mem_we, 1'b0);
        tick();
        chk1("ld1_rsp_valid1", rsp_valid_1, 1'b1);
        chk("ld1_rdata1", rsp_rdata_1, 32'hDEAD_BEEF);
        chk1("ld1_rsp_err1", rsp_err_1, 1'b0);

        // Illegal store code on port0: accepted, no write, error response
        drive1(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        drive0(1'b1, 32'h0001_0004, 1'b1, 32'h1234_5678, 3'b100);
        #1;
        chk1("ill_ready0", req_ready_0, 1'b1);
        chk1("ill_mem_we", mem_we, 1'b0);
        tick();
        chk1("ill_rsp_valid0", rsp_valid_0, 1'b1);
        chk1("ill_rsp_err0", rsp_err_0, 1'b1);
        chk("ill_rdata0", rsp_rdata_0, 32'h0);
        drive0(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        tick();
        chk1("idle_rsp_valid0", rsp_valid_0, 1'b0);
        chk1("idle_rsp_err0", rsp_err_0, 1'b0);
        chk("idle_mem_a", mem_a, 32'h0);
        chk("idle_memctrl", {29'h0, mem_memcontrol}, 32'h2);
        chk("ill_mem_unchanged", mem[1], 32'h5566_7788);

        // Reset right after a port0 load transfer kills its response
        drive0(1'b1, 32'h0001_0000, 1'b0, 32'h0, 3'b010);
        tick();
        rst_n = 1'b0;
        drive0(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        #1;
        chk1("rstmid_rsp_valid0", rsp_valid_0, 1'b0);
        chk("rstmid_rdata0", rsp_rdata_0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive0(1'b1, 32'h0001_0000, 1'b0, 32'h0, 3'b010);
        drive1(1'b1, 32'h0001_0004, 1'b0, 32'h0, 3'b010);
        #1;
        chk1("rel_ready0", req_ready_0, 1'b1);
        chk1("rel_ready1", req_ready_1, 1'b0);
        tick();
        chk1("rel_rsp_valid0", rsp_valid_0, 1'b1);
        chk("rel_rdata0", rsp_rdata_0, 32'h1122_3344);

        // Byte store then back-to-back signed/unsigned/illegal byte loads on port0
        drive1(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        drive0(1'b1, 32'h0001_0003, 1'b1, 32'h0000_0080, 3'b000);
        #1;
        chk1("sb_mem_we", mem_we, 1'b1);
        chk("sb_wdata", mem_writedata, 32'h0000_0080);
        tick();
        chk1("sb_rsp_valid0", rsp_valid_0, 1'b1);
        chk("sb_rdata0_hold", rsp_rdata_0, 32'h1122_3344);
        drive0(1'b1, 32'h0001_0003, 1'b0, 32'h0, 3'b000);
        tick();
        chk1("lb_rsp_valid0", rsp_valid_0, 1'b1);
        chk("lb_rdata0", rsp_rdata_0, 32'hFFFF_FF80);
        drive0(1'b1, 32'h0001_0003, 1'b0, 32'h0, 3'b100);
        tick();
        chk1("lbu_rsp_valid0", rsp_valid_0, 1'b1);
        chk("lbu_rdata0", rsp_rdata_0, 32'h0000_0080);
        chk1("lbu_rsp_err0", rsp_err_0, 1'b0);
        drive0(1'b1, 32'h0001_0000, 1'b0, 32'h0, 3'b011);
        tick();
        chk1("ldill_rsp_valid0", rsp_valid_0, 1'b1);
        chk1("ldill_rsp_err0", rsp_err_0, 1'b1);
        chk("ldill_rdata0", rsp_rdata_0, 32'h0);
        chk1("b2b_rsp_valid1", rsp_valid_1, 1'b0);
        drive0(1'b0, 32'h0, 1'b0, 32'h0, 3'b010);
        tick();
        chk1("end_rsp_valid0", rsp_valid_0, 1'b0);
        chk("sb_mem_word", mem[0], 32'h8022_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
